// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage controller for a 5-stage RISC-V pipeline.
// Picks the PC source, stalls the PC, flushes IF/ID and ID/EX, tracks
// boot/refill/halt phases and keeps saturating redirect/stall counters.
// All control outputs are Mealy: decoded each cycle from state and inputs.
module pc_fetch_ctrl #(
   parameter int BOOT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_ID,
   input  logic        br_taken_EX,
   input  logic        jalr_EX,
   input  logic        imem_ready,
   input  logic        halt_req,
   output logic        pc_en,
   output logic [1:0]  pc_sel,
   output logic        flush_IF_ID,
   output logic        flush_ID_EX,
   output logic        fetch_valid,
   output logic        halted,
   output logic [15:0] redirect_cnt,
   output logic [15:0] stall_cnt,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_REFILL = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   localparam logic [3:0]  BOOT_INIT = 4'(BOOT_CYCLES - 1);
   localparam logic [1:0]  SEL_SEQ   = 2'b00;
   localparam logic [1:0]  SEL_BR    = 2'b01;
   localparam logic [1:0]  SEL_JALR  = 2'b11;
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   state_t      state_q, state_d;
   logic [3:0]  boot_cnt_q, boot_cnt_d;
   logic [15:0] redirect_cnt_q, redirect_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        redirect_evt;
   logic        stall_evt;
   logic        in_refill;

   assign in_refill    = (state_q == ST_REFILL);
   assign redirect_cnt = redirect_cnt_q;
   assign stall_cnt    = stall_cnt_q;
   assign dbg_state    = state_q;

   // Next-state and output decode; the RUN/REFILL branch order is the
   // hazard priority: halt > jalr > branch > imem wait > load-use stall.
   always_comb begin
      state_d      = state_q;
      boot_cnt_d   = boot_cnt_q;
      pc_en        = 1'b0;
      pc_sel       = SEL_SEQ;
      flush_IF_ID  = 1'b0;
      flush_ID_EX  = 1'b0;
      fetch_valid  = 1'b0;
      halted       = 1'b0;
      redirect_evt = 1'b0;
      stall_evt    = 1'b0;
      case (state_q)
         ST_BOOT: begin
            if (boot_cnt_q == 4'd0) begin
               state_d = ST_RUN;
            end else begin
               boot_cnt_d = boot_cnt_q - 4'd1;
            end
         end
         ST_RUN, ST_REFILL: begin
            if (halt_req) begin
               flush_IF_ID = 1'b1;
               flush_ID_EX = 1'b1;
               state_d     = ST_HALT;
            end else if (jalr_EX || br_taken_EX) begin
               // jalr wins when both resolve together; still one redirect
               pc_en        = 1'b1;
               pc_sel       = jalr_EX ? SEL_JALR : SEL_BR;
               flush_IF_ID  = 1'b1;
               flush_ID_EX  = 1'b1;
               redirect_evt = 1'b1;
               state_d      = ST_REFILL;
            end else if (!imem_ready) begin
               // waiting on memory: hold everything, stay in this state
               stall_evt = 1'b1;
            end else if (stall_ID) begin
               // load-use bubble: hold PC and IF/ID, squash ID/EX
               flush_ID_EX = 1'b1;
               fetch_valid = !in_refill;
               stall_evt   = 1'b1;
               state_d     = ST_RUN;
            end else begin
               pc_en       = 1'b1;
               fetch_valid = !in_refill;
               state_d     = ST_RUN;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // Saturating performance counters
   always_comb begin
      redirect_cnt_d = redirect_cnt_q;
      stall_cnt_d    = stall_cnt_q;
      if (redirect_evt && (redirect_cnt_q != CNT_MAX)) begin
         redirect_cnt_d = redirect_cnt_q + 16'd1;
      end
      if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // State and counter registers; reset returns to BOOT with nothing pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_BOOT;
         boot_cnt_q     <= BOOT_INIT;
         redirect_cnt_q <= 16'd0;
         stall_cnt_q    <= 16'd0;
      end else begin
         state_q        <= state_d;
         boot_cnt_q     <= boot_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed bench for pc_fetch_ctrl (BOOT_CYCLES=2).
// Expected control vectors are queued as each step is driven and popped
// when the outputs are sampled on the falling edge.
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stall_ID;
   logic        br_taken_EX;
   logic        jalr_EX;
   logic        imem_ready;
   logic        halt_req;
   logic        pc_en;
   logic [1:0]  pc_sel;
   logic        flush_IF_ID;
   logic        flush_ID_EX;
   logic        fetch_valid;
   logic        halted;
   logic [15:0] redirect_cnt;
   logic [15:0] stall_cnt;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   // expected {pc_en, pc_sel[1:0], flush_IF_ID, flush_ID_EX, fetch_valid, halted}
   logic [6:0] exp_q[$];

   localparam logic [6:0] E_IDLE     = 7'b0_00_0_0_0_0;
   localparam logic [6:0] E_SEQ      = 7'b1_00_0_0_1_0;
   localparam logic [6:0] E_REF_SEQ  = 7'b1_00_0_0_0_0;
   localparam logic [6:0] E_BR       = 7'b1_01_1_1_0_0;
   localparam logic [6:0] E_JALR     = 7'b1_11_1_1_0_0;
   localparam logic [6:0] E_STALL    = 7'b0_00_0_1_1_0;
   localparam logic [6:0] E_REF_STL  = 7'b0_00_0_1_0_0;
   localparam logic [6:0] E_HALT_REQ = 7'b0_00_1_1_0_0;
   localparam logic [6:0] E_HALT     = 7'b0_00_0_0_0_1;

   // input vector {halt_req, jalr_EX, br_taken_EX, imem_ready, stall_ID}
   localparam logic [4:0] I_NONE  = 5'b00000;
   localparam logic [4:0] I_SEQ   = 5'b00010;
   localparam logic [4:0] I_BR    = 5'b00110;
   localparam logic [4:0] I_JALR  = 5'b01010;
   localparam logic [4:0] I_BOTH0 = 5'b01100;
   localparam logic [4:0] I_STALL = 5'b00011;
   localparam logic [4:0] I_STL_W = 5'b00001;
   localparam logic [4:0] I_WAIT  = 5'b00000;
   localparam logic [4:0] I_HALT  = 5'b10110;

   pc_fetch_ctrl #(.BOOT_CYCLES(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_ID     (stall_ID),
      .br_taken_EX  (br_taken_EX),
      .jalr_EX      (jalr_EX),
      .imem_ready   (imem_ready),
      .halt_req     (halt_req),
      .pc_en        (pc_en),
      .pc_sel       (pc_sel),
      .flush_IF_ID  (flush_IF_ID),
      .flush_ID_EX  (flush_ID_EX),
      .fetch_valid  (fetch_valid),
      .halted       (halted),
      .redirect_cnt (redirect_cnt),
      .stall_cnt    (stall_cnt),
      .dbg_state    (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [4:0] in);
      {halt_req, jalr_EX, br_taken_EX, imem_ready, stall_ID} = in;
   endtask

   task automatic check_out(input string tag);
      logic [6:0] got;
      logic [6:0] exp;
      got = {pc_en, pc_sel, flush_IF_ID, flush_ID_EX, fetch_valid, halted};
      exp = exp_q.pop_front();
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s ctrl observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic check_cnt(input string tag, input logic [15:0] exp_red,
                            input logic [15:0] exp_stl);
      checks++;
      assert (redirect_cnt === exp_red && stall_cnt === exp_stl) else begin
         failures++;
         $error("FAIL %s counters observed=%h/%h expected=%h/%h", tag,
                redirect_cnt, stall_cnt, exp_red, exp_stl);
      end
   endtask

   // drive one cycle of inputs, queue the expectation, check at negedge
   task automatic step(input logic [4:0] in, input logic [6:0] exp, input string tag);
      drive(in);
      exp_q.push_back(exp);
      @(negedge clk);
      check_out(tag);
      @(posedge clk);
      #1;
   endtask

   // asynchronous reset pulse, checked while asserted, released after an edge
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      exp_q.push_back(E_IDLE);
      check_out(tag);
      check_cnt(tag, 16'd0, 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      drive(I_NONE);
      #2;
      do_reset("reset_init");

      // boot: two held cycles even with memory ready, then sequential fetch
      step(I_SEQ, E_IDLE, "boot0");
      step(I_SEQ, E_IDLE, "boot1");
      step(I_SEQ, E_SEQ, "run_seq0");
      step(I_SEQ, E_SEQ, "run_seq1");

      // taken branch: redirect, refill bubble, then valid again
      step(I_BR, E_BR, "br_redirect");
      step(I_SEQ, E_REF_SEQ, "br_refill");
      step(I_SEQ, E_SEQ, "br_back_run");
      check_cnt("br_counts", 16'd1, 16'd0);

      // load-use stall for three cycles
      for (int i = 0; i < 3; i++) step(I_STALL, E_STALL, "stall_id");
      step(I_SEQ, E_SEQ, "stall_release");
      check_cnt("stall_counts", 16'd1, 16'd3);

      // jalr and branch together while memory is not ready: jalr wins
      step(I_BOTH0 | I_JALR & 5'b11100, E_JALR, "jalr_br_both");
      step(I_WAIT, E_IDLE, "refill_wait");
      step(I_SEQ, E_REF_SEQ, "refill_ready");
      step(I_SEQ, E_SEQ, "jalr_back_run");
      check_cnt("jalr_counts", 16'd2, 16'd4);

      // redirect while refilling, then a stall in REFILL leaves to RUN
      step(I_BR, E_BR, "br_again");
      step(I_JALR, E_JALR, "jalr_in_refill");
      step(I_STALL, E_REF_STL, "refill_stall");
      step(I_SEQ, E_SEQ, "refill_exit");
      check_cnt("refill_counts", 16'd4, 16'd5);

      // memory wait outranks a load-use stall
      step(I_STL_W, E_IDLE, "wait_over_stall");
      check_cnt("wait_counts", 16'd4, 16'd6);

      // halt outranks a simultaneous branch, then every input is ignored
      step(I_HALT, E_HALT_REQ, "halt_req");
      for (int i = 0; i < 10; i++) begin
         step(5'($urandom_range(0, 31)), E_HALT, "halt_hold");
      end
      check_cnt("halt_counts", 16'd4, 16'd6);

      // reset out of HALT
      do_reset("reset_from_halt");
      step(I_BR, E_IDLE, "boot0_after_halt");
      step(I_JALR, E_IDLE, "boot1_after_halt");
      step(I_SEQ, E_SEQ, "run_after_halt");

      // reset in the middle of a redirect leaves nothing pending
      drive(I_BR);
      exp_q.push_back(E_BR);
      @(negedge clk);
      check_out("mid_redirect");
      #2;
      do_reset("reset_mid_redirect");
      step(I_SEQ, E_IDLE, "boot0_after_redir");
      step(I_SEQ, E_IDLE, "boot1_after_redir");
      step(I_SEQ, E_SEQ, "run_after_redir");
      check_cnt("redir_reset_counts", 16'd0, 16'd0);

      // saturate the stall counter with a long memory wait
      drive(I_WAIT);
      repeat (70000) @(posedge clk);
      #1;
      check_cnt("stall_saturate", 16'd0, 16'hFFFF);
      step(I_WAIT, E_IDLE, "stall_sat_hold");
      check_cnt("stall_sat_still", 16'd0, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
